// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose rd feeds the decode slot inserts exactly one bubble; flush squashes the slot.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rs3,
  input  logic [DATA_W-1:0] id_s1,
  input  logic [DATA_W-1:0] id_s2,
  input  logic [DATA_W-1:0] id_s3,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [5:0]        id_op,
  input  logic              id_is_load,
  input  logic              id_reg_write,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic              ex_is_load,
  output logic              ex_reg_write,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_c,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rd,
  output logic [5:0]        ex_op,
  output logic [15:0]       perf_bubbles
);

  logic              vld_p1, load_p1, wr_p1;
  logic [DATA_W-1:0] a_p1, b_p1, c_p1, imm_p1;
  logic [4:0]        rd_p1;
  logic [5:0]        op_p1;
  logic [15:0]       bubbles_p1;
  logic              hazard;
  logic              advance;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard   = vld_p1 & load_p1 & (rd_p1 != 5'd0) &
                    ((rd_p1 == id_rs1) | (rd_p1 == id_rs2) | (rd_p1 == id_rs3));
  assign stall_id = hazard & id_valid & ~flush;
  assign advance  = ~flush & ~stall_id;

  // ---- ID -> EX boundary (p1): control ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      load_p1    <= 1'b0;
      wr_p1      <= 1'b0;
      bubbles_p1 <= 16'd0;
    end else if (!advance) begin
      vld_p1  <= 1'b0;
      load_p1 <= 1'b0;
      wr_p1   <= 1'b0;
      if (stall_id) bubbles_p1 <= sat_inc(bubbles_p1);
    end else begin
      vld_p1  <= id_valid;
      load_p1 <= id_valid & id_is_load;
      wr_p1   <= id_valid & id_reg_write;
    end
  end

  // ---- ID -> EX boundary (p1): data, held across bubbles and flushes ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_p1   <= '0;
      b_p1   <= '0;
      c_p1   <= '0;
      imm_p1 <= '0;
      rd_p1  <= 5'd0;
      op_p1  <= 6'd0;
    end else if (advance) begin
      a_p1   <= id_s1;
      b_p1   <= id_s2;
      c_p1   <= id_s3;
      imm_p1 <= id_imm;
      rd_p1  <= id_rd;
      op_p1  <= id_op;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_is_load   = load_p1;
  assign ex_reg_write = wr_p1;
  assign ex_a         = a_p1;
  assign ex_b         = b_p1;
  assign ex_c         = c_p1;
  assign ex_imm       = imm_p1;
  assign ex_rd        = rd_p1;
  assign ex_op        = op_p1;
  assign perf_bubbles = bubbles_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-cycle expected EX state is queued at drive time
// and popped after the following rising edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_is_load, id_reg_write, flush;
  logic [4:0]  id_rs1, id_rs2, id_rs3, id_rd;
  logic [31:0] id_s1, id_s2, id_s3, id_imm;
  logic [5:0]  id_op;
  logic        stall_id, ex_valid, ex_is_load, ex_reg_write;
  logic [31:0] ex_a, ex_b, ex_c, ex_imm;
  logic [4:0]  ex_rd;
  logic [5:0]  ex_op;
  logic [15:0] perf_bubbles;

  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_s1(id_s1), .id_s2(id_s2), .id_s3(id_s3),
    .id_rd(id_rd), .id_imm(id_imm), .id_op(id_op),
    .id_is_load(id_is_load), .id_reg_write(id_reg_write), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_reg_write(ex_reg_write), .ex_a(ex_a), .ex_b(ex_b), .ex_c(ex_c),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_op(ex_op), .perf_bubbles(perf_bubbles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, is_load, reg_write;
    logic [31:0] a, b, c, imm;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [15:0] bubbles;
  } ex_t;

  ex_t m;
  ex_t sbq[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    m = '{valid: 1'b0, is_load: 1'b0, reg_write: 1'b0, a: '0, b: '0, c: '0,
          imm: '0, rd: 5'd0, op: 6'd0, bubbles: 16'd0};
  endtask

  // Called after a falling edge: drive the decode slot, check stall, advance one edge, check EX.
  task automatic cyc(input logic v, input logic ld, input logic rw, input logic fl,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                     input logic [4:0] rd, input logic [5:0] op,
                     input logic [31:0] s1, input logic [31:0] s2, input string tag);
    logic hz, es;
    ex_t  e;
    id_valid = v; id_is_load = ld; id_reg_write = rw; flush = fl;
    id_rs1 = rs1; id_rs2 = rs2; id_rs3 = rs3; id_rd = rd; id_op = op;
    id_s1 = s1; id_s2 = s2; id_s3 = $urandom; id_imm = $urandom;
    #1;
    hz = m.valid & m.is_load & (m.rd != 5'd0) & ((m.rd == rs1) | (m.rd == rs2) | (m.rd == rs3));
    es = hz & v & ~fl;
    chk({tag, ".stall_id"}, {31'd0, stall_id}, {31'd0, es});
    if (fl || es) begin
      m.valid = 1'b0; m.is_load = 1'b0; m.reg_write = 1'b0;
      if (es && m.bubbles != 16'hFFFF) m.bubbles = m.bubbles + 16'd1;
    end else begin
      m.valid = v; m.is_load = v & ld; m.reg_write = v & rw;
      m.a = s1; m.b = s2; m.c = id_s3; m.imm = id_imm; m.rd = rd; m.op = op;
    end
    sbq.push_back(m);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".ex_valid"},     {31'd0, ex_valid},     {31'd0, e.valid});
      chk({tag, ".ex_is_load"},   {31'd0, ex_is_load},   {31'd0, e.is_load});
      chk({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.reg_write});
      chk({tag, ".ex_a"},   ex_a,   e.a);
      chk({tag, ".ex_b"},   ex_b,   e.b);
      chk({tag, ".ex_c"},   ex_c,   e.c);
      chk({tag, ".ex_imm"}, ex_imm, e.imm);
      chk({tag, ".ex_rd"},  {27'd0, ex_rd}, {27'd0, e.rd});
      chk({tag, ".ex_op"},  {26'd0, ex_op}, {26'd0, e.op});
      chk({tag, ".perf_bubbles"}, {16'd0, perf_bubbles}, {16'd0, e.bubbles});
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    id_valid = 0; id_is_load = 0; id_reg_write = 0; flush = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs3 = 0; id_rd = 0; id_op = 0;
    id_s1 = 0; id_s2 = 0; id_s3 = 0; id_imm = 0;
    zero_model();
    #2;
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.ex_a", ex_a, 32'd0);
    chk("rst.perf_bubbles", {16'd0, perf_bubbles}, 32'd0);
    chk("rst.stall_id", {31'd0, stall_id}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Plain advance
    cyc(1, 0, 1, 0, 5'd1, 5'd2, 5'd0, 5'd5, 6'h20, 32'h11, 32'h22, "adv");
    chk("adv.const_a", ex_a, 32'h11);
    chk("adv.const_rd", {27'd0, ex_rd}, 32'd5);

    // Load-use on rs2: one bubble, then the dependent instruction advances
    cyc(1, 1, 1, 0, 5'd3, 5'd4, 5'd0, 5'd7, 6'h03, 32'hA0, 32'hB0, "ld7");
    cyc(1, 0, 1, 0, 5'd1, 5'd7, 5'd0, 5'd8, 6'h21, 32'hC0, 32'hD0, "use7");
    chk("use7.bubbles_const", {16'd0, perf_bubbles}, 32'd1);
    cyc(1, 0, 1, 0, 5'd1, 5'd7, 5'd0, 5'd8, 6'h21, 32'hC0, 32'hD0, "use7b");

    // Load to r0 never stalls
    cyc(1, 1, 0, 0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h03, 32'h1, 32'h2, "ld0");
    cyc(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 5'd9, 6'h22, 32'h3, 32'h4, "use0");

    // Flush beats stall and does not count a bubble
    cyc(1, 1, 1, 0, 5'd1, 5'd2, 5'd0, 5'd9, 6'h03, 32'h5, 32'h6, "ld9");
    cyc(1, 0, 1, 1, 5'd0, 5'd0, 5'd9, 5'd10, 6'h23, 32'h7, 32'h8, "flush");

    // Invalid slot: no stall, control bits squashed
    cyc(1, 1, 1, 0, 5'd1, 5'd2, 5'd0, 5'd3, 6'h03, 32'h9, 32'hA, "ld3");
    cyc(0, 1, 1, 0, 5'd3, 5'd3, 5'd3, 5'd4, 6'h24, 32'hB, 32'hC, "inval");

    // Dependent load chain: each link stalls exactly once
    cyc(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 5'd1, 6'h03, 32'h10, 32'h20, "chain0");
    cyc(1, 1, 1, 0, 5'd1, 5'd0, 5'd0, 5'd2, 6'h03, 32'h30, 32'h40, "chain1s");
    cyc(1, 1, 1, 0, 5'd1, 5'd0, 5'd0, 5'd2, 6'h03, 32'h30, 32'h40, "chain1");
    cyc(1, 1, 1, 0, 5'd2, 5'd0, 5'd0, 5'd1, 6'h03, 32'h50, 32'h60, "chain2s");
    cyc(1, 1, 1, 0, 5'd2, 5'd0, 5'd0, 5'd1, 6'h03, 32'h50, 32'h60, "chain2");
    chk("chain.bubbles_const", {16'd0, perf_bubbles}, 32'd3);

    // Saturation from a preloaded count
    force dut.bubbles_p1 = 16'hFFFE;
    #1;
    release dut.bubbles_p1;
    m.bubbles = 16'hFFFE;
    cyc(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 5'd4, 6'h03, 32'h70, 32'h80, "sat_ld");
    cyc(1, 1, 1, 0, 5'd4, 5'd0, 5'd0, 5'd4, 6'h03, 32'h90, 32'hA0, "sat1");
    chk("sat1.const", {16'd0, perf_bubbles}, 32'h0000FFFF);
    cyc(1, 1, 1, 0, 5'd4, 5'd0, 5'd0, 5'd4, 6'h03, 32'h90, 32'hA0, "sat_adv");
    cyc(1, 0, 1, 0, 5'd4, 5'd0, 5'd0, 5'd5, 6'h25, 32'hB0, 32'hC0, "sat2");
    chk("sat2.const", {16'd0, perf_bubbles}, 32'h0000FFFF);

    // Async reset while stalling: everything clears before the next edge
    cyc(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 5'd6, 6'h03, 32'hD0, 32'hE0, "rst_ld");
    id_valid = 1; id_rs1 = 5'd6; id_is_load = 0; flush = 0;
    #1;
    chk("arst.stall_before", {31'd0, stall_id}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst.stall_id", {31'd0, stall_id}, 32'd0);
    chk("arst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst.perf_bubbles", {16'd0, perf_bubbles}, 32'd0);
    chk("arst.ex_rd", {27'd0, ex_rd}, 32'd0);
    reset_n = 1'b1;
    zero_model();
    // First edge after reset advances from an empty EX slot
    cyc(1, 0, 1, 0, 5'd6, 5'd0, 5'd0, 5'd11, 6'h26, 32'hF0, 32'hF1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port id_valid  input  1  decode slot holds a real instruction.
REQ-004 SHALL have ports id_rs1, id_rs2, id_rs3  input  5 each  source register numbers presented to the register file.
REQ-005 SHALL have ports id_s1, id_s2, id_s3  input  32 each  operand values returned by the register file, already write-through-bypassed.
REQ-006 SHALL have port id_rd  input  5  destination register number.
REQ-007 SHALL have port id_imm  input  32  sign/zero-extended immediate.
REQ-008 SHALL have port id_op  input  6  decoded ALU/opcode selector.
REQ-009 SHALL have ports id_is_load, id_reg_write  input  1 each  instruction is a load; instruction writes rd.
REQ-010 SHALL have port flush  input  1  taken branch/jump resolved in EX; squash decode slot.
REQ-011 SHALL have port stall_id  output  1  hold IF/ID and PC this cycle (combinational).
REQ-012 SHALL have ports ex_valid, ex_is_load, ex_reg_write  output  1 each  registered copies for EX.
REQ-013 SHALL have ports ex_a, ex_b, ex_c, ex_imm  output  32 each  registered operands and immediate.
REQ-014 SHALL have ports ex_rd  output  5, ex_op  output  6  registered destination and opcode.
REQ-015 SHALL have port perf_bubbles  output  16  saturating count of inserted load-use bubbles.

Function
REQ-016 hazard SHALL be 1 when ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2 | ex_rd==id_rs3); register 0 never causes a hazard.
REQ-017 stall_id SHALL equal hazard & id_valid & ~flush, same cycle, no register in path.
REQ-018 Priority per edge SHALL be flush > stall > advance.
REQ-019 Advance (no flush, no stall): all ex_* SHALL load id_* values (id_s1->ex_a, id_s2->ex_b, id_s3->ex_c), ex_valid<=id_valid; latency exactly 1 cycle.
REQ-020 Stall: ex_valid, ex_reg_write, ex_is_load SHALL load 0 (bubble); data fields (ex_a..ex_imm, ex_rd, ex_op) SHALL hold previous values.
REQ-021 Flush: ex_valid, ex_reg_write, ex_is_load SHALL load 0; data fields hold; flush SHALL NOT increment perf_bubbles.
REQ-022 id_valid=0 advance SHALL produce ex_valid=0 and ex_reg_write=0, ex_is_load=0 regardless of id_reg_write/id_is_load.
REQ-023 perf_bubbles SHALL increment by 1 on each edge where stall_id=1, saturating at 16'hFFFF (no wrap).
REQ-024 After one bubble the load leaves EX, so hazard SHALL clear next cycle; a stall SHALL never exceed 1 cycle per load-use pair.
REQ-025 Back-to-back loads with dependency chain SHALL each stall exactly once.

Reset
REQ-026 reset_n=0 SHALL immediately (asynchronously) force all ex_* outputs and perf_bubbles to 0; stall_id therefore 0.
REQ-027 Reset deassertion mid-stream SHALL resume with first edge behaving as advance from an empty EX slot.
REQ-028 Reset asserted during a stall SHALL drop the stall in the same cycle.

Verification
REQ-029 Advance: id_valid=1, id_op=6'h20, id_s1=32'h11, id_s2=32'h22, id_rd=5 -> next edge ex_valid=1, ex_a=32'h11, ex_b=32'h22, ex_rd=5, stall_id=0.
REQ-030 Load-use: EX holds load ex_rd=7; ID id_rs2=7, id_valid=1 -> stall_id=1, next edge ex_valid=0, perf_bubbles=1; following cycle stall_id=0 and instruction advances.
REQ-031 R0: EX load ex_rd=0, ID id_rs1=0 -> stall_id=0, no bubble, perf_bubbles unchanged.
REQ-032 Flush vs stall: hazard present and flush=1 same cycle -> stall_id=0, next edge ex_valid=0, perf_bubbles unchanged.
REQ-033 Saturation: preload 16'hFFFE, two stalls -> perf_bubbles 16'hFFFF then stays 16'hFFFF.
REQ-034 Async reset: pulse reset_n=0 between edges with ex_valid=1 -> ex_valid and perf_bubbles 0 before next clk edge.
